clint_mh: RTL

//   Multi-hart core-local interruptor: a 64-bit mtime with prescaler, plus per-hart mtimecmp and msip.

---
 rtl/clint_mh.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/clint_mh.sv
// Core-local interruptor for NHART harts: prescaled 64-bit mtime, per-hart mtimecmp/msip,
// AXI4-lite slave with single-outstanding read and write channels.
module clint_mh #(
  parameter int NHART    = 1,
  parameter int PRESCALE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             arvalid_i,
  output logic             arready_o,
  input  logic [31:0]      araddr_i,
  output logic             rvalid_o,
  input  logic             rready_i,
  output logic [31:0]      rdata_o,
  output logic [1:0]       rresp_o,
  input  logic             awvalid_i,
  output logic             awready_o,
  input  logic [31:0]      awaddr_i,
  input  logic             wvalid_i,
  output logic             wready_o,
  input  logic [31:0]      wdata_i,
  input  logic [3:0]       wstrb_i,
  output logic             bvalid_o,
  input  logic             bready_i,
  output logic [1:0]       bresp_o,
  output logic [NHART-1:0] msip_o,
  output logic [NHART-1:0] mtip_o
);

  localparam int            PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
  localparam logic [1:0]    OKAY   = 2'b00;
  localparam logic [1:0]    SLVERR = 2'b10;

  typedef enum logic { R_IDLE, R_RESP } r_state_t;
  typedef enum logic { W_IDLE, W_RESP } w_state_t;

  r_state_t         r_state_reg;
  w_state_t         w_state_reg;
  logic [PW-1:0]    presc_reg;
  logic [63:0]      mtime_reg;
  logic [63:0]      mtime_next;
  logic [63:0]      mtimecmp_reg  [NHART];
  logic [63:0]      mtimecmp_next [NHART];
  logic [NHART-1:0] msip_reg;
  logic [NHART-1:0] msip_next;
  logic [NHART-1:0] mtip_reg;
  logic [31:0]      rdata_reg;
  logic [1:0]       rresp_reg;
  logic [1:0]       bresp_reg;

  logic             tick;
  logic             wr_fire;
  logic [15:0]      rd_addr;
  logic [15:0]      wr_addr;
  logic             rd_ok;
  logic [31:0]      rd_word;
  logic             wr_ok;
  logic             wr_mtime_lo;
  logic             wr_mtime_hi;
  logic [NHART-1:0] wr_msip_sel;
  logic [NHART-1:0] wr_cmp_lo_sel;
  logic [NHART-1:0] wr_cmp_hi_sel;
  logic             unused_addr_bits;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    end
    return res;
  endfunction

  assign rd_addr          = araddr_i[15:0];
  assign wr_addr          = awaddr_i[15:0];
  assign unused_addr_bits = ^{araddr_i[31:16], awaddr_i[31:16]};

  assign tick      = (presc_reg == P_LAST);
  assign arready_o = (r_state_reg == R_IDLE);
  assign rvalid_o  = (r_state_reg == R_RESP);
  assign bvalid_o  = (w_state_reg == W_RESP);
  // AW and W are only ever accepted together, so one handshake term covers both.
  assign awready_o = awvalid_i && wvalid_i && (w_state_reg == W_IDLE);
  assign wready_o  = awready_o;
  assign wr_fire   = awready_o;

  assign rdata_o = rdata_reg;
  assign rresp_o = rresp_reg;
  assign bresp_o = bresp_reg;
  assign msip_o  = msip_reg;
  assign mtip_o  = mtip_reg;

  always_comb begin
    rd_ok   = 1'b0;
    rd_word = '0;
    if (rd_addr == 16'hBFF8) begin
      rd_ok   = 1'b1;
      rd_word = mtime_reg[31:0];
    end
    if (rd_addr == 16'hBFFC) begin
      rd_ok   = 1'b1;
      rd_word = mtime_reg[63:32];
    end
    for (int h = 0; h < NHART; h++) begin
      if (rd_addr == 16'(4 * h)) begin
        rd_ok   = 1'b1;
        rd_word = {31'b0, msip_reg[h]};
      end
      if (rd_addr == 16'(32'h4000 + 8 * h)) begin
        rd_ok   = 1'b1;
        rd_word = mtimecmp_reg[h][31:0];
      end
      if (rd_addr == 16'(32'h4004 + 8 * h)) begin
        rd_ok   = 1'b1;
        rd_word = mtimecmp_reg[h][63:32];
      end
    end
  end

  for (genvar gi = 0; gi < NHART; gi++) begin : g_hart
    localparam logic [15:0] MSIP_A = 16'(4 * gi);
    localparam logic [15:0] CMP_A  = 16'(32'h4000 + 8 * gi);

    assign wr_msip_sel[gi]   = wr_fire && (wr_addr == MSIP_A);
    assign wr_cmp_lo_sel[gi] = wr_fire && (wr_addr == CMP_A);
    assign wr_cmp_hi_sel[gi] = wr_fire && (wr_addr == CMP_A + 16'd4);

    // Only byte lane 0 can touch the single implemented msip bit.
    assign msip_next[gi] = (wr_msip_sel[gi] && wstrb_i[0]) ? wdata_i[0] : msip_reg[gi];

    assign mtimecmp_next[gi] =
        wr_cmp_lo_sel[gi] ? {mtimecmp_reg[gi][63:32],
                             byte_merge(mtimecmp_reg[gi][31:0], wdata_i, wstrb_i)} :
        wr_cmp_hi_sel[gi] ? {byte_merge(mtimecmp_reg[gi][63:32], wdata_i, wstrb_i),
                             mtimecmp_reg[gi][31:0]} :
                            mtimecmp_reg[gi];
  end

  assign wr_mtime_lo = wr_fire && (wr_addr == 16'hBFF8);
  assign wr_mtime_hi = wr_fire && (wr_addr == 16'hBFFC);
  assign wr_ok       = (|wr_msip_sel) || (|wr_cmp_lo_sel) || (|wr_cmp_hi_sel) ||
                       wr_mtime_lo || wr_mtime_hi;

  // A software write to either half overrides that cycle's tick, so no carry crosses words.
  always_comb begin
    mtime_next = tick ? mtime_reg + 64'd1 : mtime_reg;
    if (wr_mtime_lo) begin
      mtime_next = {mtime_reg[63:32], byte_merge(mtime_reg[31:0], wdata_i, wstrb_i)};
    end else if (wr_mtime_hi) begin
      mtime_next = {byte_merge(mtime_reg[63:32], wdata_i, wstrb_i), mtime_reg[31:0]};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      presc_reg   <= '0;
      mtime_reg   <= '0;
      msip_reg    <= '0;
      mtip_reg    <= '0;
      r_state_reg <= R_IDLE;
      w_state_reg <= W_IDLE;
      rdata_reg   <= '0;
      rresp_reg   <= OKAY;
      bresp_reg   <= OKAY;
      for (int h = 0; h < NHART; h++) begin
        mtimecmp_reg[h] <= '1;
      end
    end else begin
      presc_reg <= tick ? '0 : presc_reg + 1'b1;
      mtime_reg <= mtime_next;
      msip_reg  <= msip_next;
      for (int h = 0; h < NHART; h++) begin
        mtimecmp_reg[h] <= mtimecmp_next[h];
        mtip_reg[h]     <= (mtime_next >= mtimecmp_next[h]);
      end

      // Read snapshot uses pre-write register values, so a same-cycle write is not visible.
      if (r_state_reg == R_IDLE) begin
        if (arvalid_i) begin
          rdata_reg   <= rd_word;
          rresp_reg   <= rd_ok ? OKAY : SLVERR;
          r_state_reg <= R_RESP;
        end
      end else if (rready_i) begin
        r_state_reg <= R_IDLE;
      end

      if (w_state_reg == W_IDLE) begin
        if (wr_fire) begin
          bresp_reg   <= wr_ok ? OKAY : SLVERR;
          w_state_reg <= W_RESP;
        end
      end else if (bready_i) begin
        w_state_reg <= W_IDLE;
      end
    end
  end

endmodule
